instr_fetch_queue: RTL and testbench

//   Fetch stage front end. Holds the fetch PC and issues word reads to a multi-cycle

---
 rtl/instr_fetch_queue.sv | 128 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch front end: one outstanding imem read, returned words buffered with their PCs; state moves on the falling clock edge.
// Head appears the edge after ack with no bypass; fetch stalls when the FIFO plus the in-flight slot would overflow, and a redirect flushes.
module instr_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic                         imem_ack,
  input  logic [15:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         deq_ready,
  output logic                         deq_valid,
  output logic [15:0]                  deq_instr,
  output logic [PC_W-1:0]              deq_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_after;
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [15:0]        instr_mem_q [DEPTH];
  logic               ack_vld;
  logic               push;
  logic               pop;

  always_comb begin
    ack_vld     = imem_ack && (state_q != ST_IDLE);
    pop         = (count_q != '0) && deq_ready && !redirect;
    push        = (state_q == ST_WAIT) && ack_vld && !redirect;
    count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d     = count_after;

    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q < CNT_W'(DEPTH)) begin
          state_d = ST_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = ack_vld ? ST_IDLE : ST_DROP;
        end else if (ack_vld) begin
          fetch_pc_d = fetch_pc_q + 1'b1;
          // Keep streaming only while the next word is guaranteed a slot.
          if (count_after < CNT_W'(DEPTH)) begin
            addr_d = fetch_pc_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (ack_vld) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = addr_q;
  assign deq_valid = (count_q != '0);
  assign deq_pc    = pc_mem_q[rd_ptr_q];
  assign deq_instr = instr_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic, all checked against a queue-based model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [15:0] deq_instr;
  logic [15:0] deq_pc;
  logic [2:0]  count;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: buffered {pc,instr} words, fetch PC, one outstanding request.
  logic [31:0] m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  bit          m_pend;
  bit          m_drop;
  int          wcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_req", imem_req, m_pend);
    if (m_pend) check("imem_addr", imem_addr, m_addr);
    check("count", count, m_q.size());
    check("deq_valid", deq_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("deq_pc", deq_pc, m_q[0][31:16]);
      check("deq_instr", deq_instr, m_q[0][15:0]);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 16'h0000; m_addr = 16'h0000;
    m_pend = 0; m_drop = 0; wcnt = 0;
  endtask

  // Called just after a falling edge: drive, predict, then check after the next falling edge.
  task automatic step(input bit ack, input logic [15:0] rd, input bit redir,
                      input logic [15:0] rpc, input bit rdy);
    bit was_pend, was_drop, ack_eff;
    int old_n;
    imem_ack = ack; imem_rdata = rd; redirect = redir; redirect_pc = rpc; deq_ready = rdy;
    was_pend = m_pend; was_drop = m_drop; old_n = m_q.size();
    ack_eff = ack && was_pend;
    if (ack_eff) begin m_pend = 0; m_drop = 0; end
    if (redir) begin
      m_q.delete();
      m_pc = rpc;
      if (was_pend && !ack_eff) m_drop = 1;
    end else begin
      if (rdy && old_n > 0) void'(m_q.pop_front());
      if (ack_eff && !was_drop) begin
        m_q.push_back({m_pc, rd});
        m_pc = m_pc + 16'd1;
        if (m_q.size() < DEPTH) begin m_pend = 1; m_addr = m_pc; end
      end else if (!was_pend && old_n < DEPTH) begin
        m_pend = 1; m_addr = m_pc;
      end
    end
    if (ack_eff) wcnt = 0;
    else if (was_pend) wcnt++;
    @(negedge clock);
    #1;
    check_all();
  endtask

  // Memory answering every request after lat waiting cycles.
  task automatic run(input int n, input int lat, input bit rdy);
    for (int i = 0; i < n; i++)
      step(m_pend && (wcnt >= lat), 16'hA000 + m_addr, 1'b0, 16'h0000, rdy);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   imem_req,  1'b0);
    check({tag, "_addr"},  imem_addr, 16'h0000);
    check({tag, "_valid"}, deq_valid, 1'b0);
    check({tag, "_instr"}, deq_instr, 16'h0000);
    check({tag, "_pc"},    deq_pc,    16'h0000);
    check({tag, "_count"}, count,     3'd0);
  endtask

  initial begin
    bit reached;
    imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; deq_ready = 0;
    reset_n = 1'b1;
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;

    // Same-cycle acks, decode stalled: fills to DEPTH then stops requesting.
    run(7, 0, 1'b0);
    check("t1_count", count, 3'd4);
    check("t1_req", imem_req, 1'b0);
    check("t1_head", deq_pc, 16'h0000);

    // Slow memory with decode draining.
    run(24, 3, 1'b1);

    // Refill, then pops racing acks near full.
    run(6, 0, 1'b0);
    run(10, 0, 1'b1);

    // Redirect while waiting on address 2; late ack must be dropped.
    step(1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_pend && !m_drop && m_addr == 16'h0002) reached = 1;
      else step(m_pend, 16'hA000 + m_addr, 1'b0, 16'h0000, 1'b1);
    end
    check("t4_reach_wait2", reached, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b1);
    check("t4_valid_after_drop", deq_valid, 1'b0);
    check("t4_req_after_drop", imem_req, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    check("t4_new_addr", imem_addr, 16'h0040);
    step(1'b1, 16'hB040, 1'b0, 16'h0000, 1'b1);
    check("t4_first_pc", deq_pc, 16'h0040);

    // Redirect coinciding with ack and pop.
    run(2, 0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 16'h0100, 1'b1);
    check("t5_count", count, 3'd0);
    check("t5_valid", deq_valid, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("t5_addr", imem_addr, 16'h0100);

    // PC wrap past 16'hFFFF, then reset mid-request.
    step(m_pend, 16'hA000 + m_addr, 1'b1, 16'hFFFE, 1'b0);
    run(4, 0, 1'b0);
    check("t6_pc0", deq_pc, 16'hFFFE);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    check("t6_pc1", deq_pc, 16'hFFFF);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    check("t6_pc2", deq_pc, 16'h0000);
    check("t6_req_mid_wait", imem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("arst");
    model_reset();
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Random traffic, including stray acks with no request.
    for (int i = 0; i < 400; i++) begin
      bit a, r, d;
      a = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 1) == 1);
      step(a, 16'($urandom), r, 16'($urandom), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
